// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter family.
// UART_ARB_TAG_EN adds the TAG state that sends an ASCII requester-index byte before each packet.
package uart_pkg;

  localparam int         BUSY_WAIT_MAX_DEF = 4;
  localparam logic [7:0] UART_TAG_BASE     = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
`ifdef UART_ARB_TAG_EN
    ST_WAIT_LO = 3'd4,
    ST_TAG     = 3'd5
`else
    ST_WAIT_LO = 3'd4
`endif
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot_s;
  logic [N-1:0] oh_s;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_s = N'({req, req} >> ptr);
    oh_s  = rot_s & (~rot_s + N'(1));
    gnt   = N'(({oh_s, oh_s} << ptr) >> N);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one byte-serial UART TX among NUM_REQ requesters.
// Optional macro UART_ARB_TAG_EN: prefix every granted packet with tag byte 8'h30+index.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BUSY_WAIT_MAX = BUSY_WAIT_MAX_DEF
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 uart_wr_o,
  output logic [7:0]           uart_dat_o,
  input  logic                 uart_busy_i,
  output logic                 active_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_WAIT_MAX + 1);

  arb_state_e         state_r, state_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s, pick_s, ready_s;
  logic [PTR_W-1:0]   ptr_r, ptr_nxt_s, gidx_r, gidx_nxt_s;
  logic [7:0]         dat_r, dat_nxt_s;
  logic               last_r, last_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               wr_r, active_r;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_rr_pick (
    .req (req_valid_i),
    .ptr (ptr_r),
    .gnt (pick_s)
  );

  // Next-state and datapath decisions; the grant stays locked until the last byte clears busy.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    gidx_nxt_s  = gidx_r;
    ptr_nxt_s   = ptr_r;
    dat_nxt_s   = dat_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    ready_s     = '0;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_nxt_s = pick_s;
          gidx_nxt_s  = onehot_to_idx(pick_s);
`ifdef UART_ARB_TAG_EN
          state_nxt_s = ST_TAG;
`else
          state_nxt_s = ST_ISSUE;
`endif
        end else begin
          grant_nxt_s = '0;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        dat_nxt_s   = UART_TAG_BASE + {{(8-PTR_W){1'b0}}, gidx_r};
        last_nxt_s  = 1'b0;
        state_nxt_s = ST_SEND;
      end
`endif
      ST_ISSUE: begin
        if (req_valid_i[gidx_r] && !uart_busy_i) begin
          ready_s     = grant_r;
          dat_nxt_s   = req_data_i[{gidx_r, 3'b000} +: 8];
          last_nxt_s  = req_last_i[gidx_r];
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_SEND: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (uart_busy_i || (cnt_r == CNT_W'(BUSY_WAIT_MAX - 1))) begin
          cnt_nxt_s   = '0;
          state_nxt_s = ST_WAIT_LO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!uart_busy_i) begin
          if (last_r) begin
            ptr_nxt_s   = (gidx_r == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_r + PTR_W'(1);
            grant_nxt_s = '0;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_WAIT_LO;
        end
      end
      default: begin
        grant_nxt_s = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state_r <= ST_IDLE;
    else           state_r <= state_nxt_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      grant_r  <= '0;
      gidx_r   <= '0;
      ptr_r    <= '0;
      dat_r    <= 8'h00;
      last_r   <= 1'b0;
      cnt_r    <= '0;
      wr_r     <= 1'b0;
      active_r <= 1'b0;
    end else begin
      grant_r  <= grant_nxt_s;
      gidx_r   <= gidx_nxt_s;
      ptr_r    <= ptr_nxt_s;
      dat_r    <= dat_nxt_s;
      last_r   <= last_nxt_s;
      cnt_r    <= cnt_nxt_s;
      wr_r     <= (state_nxt_s == ST_SEND);
      active_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign req_ready_o = ready_s;
  assign grant_o     = grant_r;
  assign uart_wr_o   = wr_r;
  assign uart_dat_o  = dat_r;
  assign active_o    = active_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with requester queues and a busy-counter UART model.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        uart_wr, busy, active;
  logic [7:0]  uart_dat;

  logic [8:0] rq [4][$];
  logic [3:0] en;
  logic [7:0] log_q[$];
  int         wr_cyc_q[$];
  logic [7:0] exp_q[$];
  int checks, errors, cyc, busy_len, busy_cnt, wr_busy_viol, ready_viol, base, c0;
  logic [3:0] xfer_r;
  logic       wr_seen;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_WAIT_MAX(4)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .uart_wr_o   (uart_wr),
    .uart_dat_o  (uart_dat),
    .uart_busy_i (busy),
    .active_o    (active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      if (rq[k].size() > 0 && en[k]) begin
        req_valid[k]       = 1'b1;
        req_last[k]        = rq[k][0][8];
        req_data[8*k +: 8] = rq[k][0][7:0];
      end else begin
        req_valid[k]       = 1'b0;
        req_last[k]        = 1'b0;
        req_data[8*k +: 8] = 8'h00;
      end
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < 4; k++) if (rq[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: update inputs just after the rising edge, sample outputs on the falling edge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 4; k++) if (xfer_r[k]) void'(rq[k].pop_front());
    if (wr_seen) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    busy = (busy_cnt != 0);
    refresh();
    @(negedge clk);
    xfer_r  = req_valid & req_ready;
    wr_seen = uart_wr;
    if (uart_wr) begin
      log_q.push_back(uart_dat);
      wr_cyc_q.push_back(cyc);
      if (busy) wr_busy_viol++;
    end
    if (((req_ready & ~grant) != 4'b0000) || ($countones(req_ready) > 1)) ready_viol++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while ((active || pending()) && i < budget) begin
      step();
      i++;
    end
    chk({tag, "_idle_timeout"}, 32'(i < budget), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int i = 0;
    while (log_q.size() < n && i < budget) begin
      step();
      i++;
    end
    chk({tag, "_wr_timeout"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic exp_tag(input int g);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'h30 + 8'(g));
`endif
  endtask

  task automatic cmp_log(input string tag, input int b);
    chk({tag, "_count"}, 32'(log_q.size() - b), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < log_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(log_q[b+i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; busy_len = 3; busy_cnt = 0;
    wr_busy_viol = 0; ready_viol = 0; xfer_r = 4'b0000; wr_seen = 1'b0;
    en = 4'b1111; busy = 1'b0; rst = 1'b1;
    refresh();
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr", 32'(uart_wr), 32'd0);
    chk("rst_dat", 32'(uart_dat), 32'h00);
    chk("rst_active", 32'(active), 32'd0);
    rst = 1'b0;

    // Single request, latency and return to idle.
    base = log_q.size();
    rq[0].push_back({1'b1, 8'h41});
    step();
    c0 = cyc;
    chk("t1_c0_grant", 32'(grant), 32'd0);
    step();
    chk("t1_c1_cycle", 32'(cyc - c0), 32'd1);
    chk("t1_c1_grant", 32'(grant), 32'b0001);
    chk("t1_c1_ready", 32'(req_ready), (TAGN == 1) ? 32'b0000 : 32'b0001);
    step();
    chk("t1_c2_wr", 32'(uart_wr), 32'd1);
    chk("t1_c2_dat", 32'(uart_dat), (TAGN == 1) ? 32'h30 : 32'h41);
    wait_idle("t1", 100);
    chk("t1_end_active", 32'(active), 32'd0);
    chk("t1_end_grant", 32'(grant), 32'd0);
    exp_tag(0); exp_q.push_back(8'h41);
    cmp_log("t1", base);

    // Contention between 1 and 2; 1 then gets lowest priority for its second packet.
    base = log_q.size();
    rq[1].push_back({1'b0, 8'h11}); rq[1].push_back({1'b0, 8'h22});
    rq[1].push_back({1'b1, 8'h33}); rq[1].push_back({1'b1, 8'h44});
    rq[2].push_back({1'b0, 8'hAA}); rq[2].push_back({1'b0, 8'hBB});
    rq[2].push_back({1'b1, 8'hCC});
    wait_idle("t2", 2000);
    exp_tag(1); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_tag(2); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
    exp_tag(1); exp_q.push_back(8'h44);
    cmp_log("t2", base);

    // Lock hold: 3 stalls mid-packet while 0 waits.
    base = log_q.size();
    rq[3].push_back({1'b0, 8'h5A}); rq[3].push_back({1'b1, 8'h5B});
    rq[0].push_back({1'b1, 8'h01});
    wait_log("t3", base + TAGN + 1, 200);
    en[3] = 1'b0;
    repeat (20) step();
    chk("t3_hold_grant", 32'(grant), 32'b1000);
    chk("t3_hold_wr", 32'(log_q.size() - base), 32'(TAGN + 1));
    en[3] = 1'b1;
    wait_idle("t3", 500);
    exp_tag(3); exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    exp_tag(0); exp_q.push_back(8'h01);
    cmp_log("t3", base);

    // Long busy pacing, then busy tied low to exercise the WAIT_HI timeout.
    busy_len = 1000;
    base = log_q.size();
    rq[0].push_back({1'b0, 8'h61}); rq[0].push_back({1'b1, 8'h62});
    wait_idle("t4a", 5000);
    if (wr_cyc_q.size() >= base + TAGN + 2)
      chk("t4a_interval", 32'(wr_cyc_q[base+TAGN+1] - wr_cyc_q[base+TAGN]), 32'd1003);
    exp_tag(0); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    cmp_log("t4a", base);
    busy_len = 0;
    base = log_q.size();
    rq[1].push_back({1'b0, 8'h71}); rq[1].push_back({1'b1, 8'h72});
    wait_idle("t4b", 200);
    if (wr_cyc_q.size() >= base + TAGN + 2)
      chk("t4b_interval", 32'(wr_cyc_q[base+TAGN+1] - wr_cyc_q[base+TAGN]), 32'd7);
    exp_tag(1); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    cmp_log("t4b", base);

    // Reset during WAIT_LO, then the pointer must restart at 0.
    busy_len = 5;
    base = log_q.size();
    rq[2].push_back({1'b0, 8'h81}); rq[2].push_back({1'b1, 8'h82});
    wait_log("t5", base + TAGN + 1, 200);
    step(); step();
    chk("t5_pre_active", 32'(active), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_wr", 32'(uart_wr), 32'd0);
    chk("t5_rst_active", 32'(active), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 4; k++) rq[k].delete();
    xfer_r = 4'b0000;
    refresh();
    @(negedge clk);
    rst = 1'b0;
    base = log_q.size();
    rq[3].push_back({1'b1, 8'hD3});
    rq[1].push_back({1'b1, 8'hD1});
    wait_idle("t5", 500);
    exp_tag(1); exp_q.push_back(8'hD1);
    exp_tag(3); exp_q.push_back(8'hD3);
    cmp_log("t5", base);

    chk("wr_while_busy", 32'(wr_busy_viol), 32'd0);
    chk("ready_onehot_granted", 32'(ready_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-serial UART transmitter among NUM_REQ requesters.
- Uses round-robin arbitration with packet lock: a grant is held until the requester's byte flagged "last" has been handed to the UART, so messages never interleave.
- Paces writes against the transmitter's busy flag, issuing one 1-cycle write strobe per byte.
- Sits between the debug/status producers and the UART TX core.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BUSY_WAIT_MAX, 4: cycles to wait for uart_busy_i to rise after a write before moving on anyway.

Ports:
- sys_clk_i  input  1  system clock (100 MHz)
- sys_rst_i  input  1  asynchronous, active-high reset
- req_valid_i  input  NUM_REQ  per-requester byte valid
- req_last_i  input  NUM_REQ  byte is the last byte of a packet
- req_data_i  input  8*NUM_REQ  packed bytes; requester k occupies bits [8k+7:8k]
- req_ready_o  output  NUM_REQ  one-hot accept strobe; byte transfers when valid&ready
- grant_o  output  NUM_REQ  one-hot current owner; 0 when idle
- uart_wr_o  output  1  1-cycle write strobe to the UART
- uart_dat_o  output  8  byte to transmit, registered, stable while uart_wr_o is high
- uart_busy_i  input  1  UART shifting; goes high the cycle after an accepted write
- active_o  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state IDLE, rr pointer 0, grant_o 0, req_ready_o 0, uart_wr_o 0, uart_dat_o 8'h00, active_o 0, wait counter 0.
- Reset mid-transfer aborts silently. The current packet is lost, and the UART may finish its in-flight byte.
- States: IDLE, ISSUE, SEND, WAIT_HI, WAIT_LO (plus TAG when the optional feature is enabled).
- IDLE:
  - If any req_valid_i is high, pick the first set index searching from the rr pointer upward with wrap.
  - Register grant_o to that index and go to ISSUE.
  - If none is valid, stay in IDLE.
- ISSUE:
  - If the granted valid is high and uart_busy_i is low, assert req_ready_o[g] combinationally that cycle.
  - Latch the data into uart_dat_o and the last flag into last_q, then go to SEND.
  - If valid is low, hold ISSUE with the grant locked; no other requester may preempt.
- SEND: uart_wr_o=1 for exactly this cycle; go to WAIT_HI.
- WAIT_HI:
  - Wait for uart_busy_i=1, then go to WAIT_LO.
  - If BUSY_WAIT_MAX cycles elapse without busy, go to WAIT_LO anyway.
- WAIT_LO: when uart_busy_i=0:
  - If last_q is set: rr pointer = g+1 mod NUM_REQ, grant_o=0, go to IDLE.
  - Otherwise go to ISSUE.
- Latency:
  - valid seen in IDLE at cycle 0 -> grant_o at cycle 1 -> ready at cycle 1 -> uart_wr_o at cycle 2.
  - A new byte is never accepted before the previous one leaves busy.
- Simultaneous requests: strict round-robin order from the pointer. A requester that just finished gets the lowest priority on the next arbitration.
- Single-byte packet: last=1 on the first byte releases the grant after that byte.
- req_ready_o is only ever asserted for the granted index, at most once per byte.
- The rr pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro UART_ARB_TAG_EN.
- Defined: on each new grant, before the first payload byte, the arbiter sends tag byte 8'h30+g (ASCII digit of the requester index).
  - The tag goes through the same SEND/WAIT_HI/WAIT_LO sequence.
  - State TAG follows IDLE and precedes ISSUE; req_ready_o stays 0 during TAG.
- Undefined: no TAG state; payload bytes only.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum type;
  - UART_TAG_BASE = 8'h30;
  - the default BUSY_WAIT_MAX.
- One sub-module, rr_pick: combinational round-robin one-hot picker (request vector, pointer -> one-hot grant). It is reusable by later arbiters.

Test Plan:
- Single request: requester 0 sends 8'h41 with last=1.
  - Expect grant_o=0001 at cycle 1, ready at cycle 1, uart_wr_o at cycle 2 with uart_dat_o=8'h41.
  - Expect return to IDLE after busy falls.
- Contention: requesters 1 and 2 both valid, each sending 3-byte packets (11 22 33 and AA BB CC).
  - Expect UART byte order 11 22 33 AA BB CC with no interleaving.
  - Then requester 1 again: it is served only after 2 when 2 re-requests.
- Lock hold: requester 3 drops valid after byte 1 of 2 while requester 0 is valid.
  - Expect grant to stay 1000 and no uart_wr_o until requester 3 resumes and sends its last byte.
- Busy pacing: model the UART with busy high for 1000 cycles after each write.
  - Expect exactly one uart_wr_o per byte and none while busy.
  - With busy tied low, WAIT_HI times out after 4 cycles.
- Reset mid-packet: assert sys_rst_i during WAIT_LO.
  - Expect grant_o=0, uart_wr_o=0 and active_o=0 immediately.
  - After release, the rr pointer restarts at 0.
- With UART_ARB_TAG_EN: requester 2 sends 8'h55 last=1.
  - Expect UART bytes 8'h32 then 8'h55, and req_ready_o low during the tag byte.
